// File: rtl/encoder_15_7_core.sv
// Systematic BCH(15,7) encoder: one-cycle registered codeword {msg, msg(x)*x^8 mod g(x)}.
// Optional self-check (syndrome of the registered word) enabled by ENCODER_15_7_SELFCHECK_EN.
module encoder_15_7_core #(
    parameter logic [8:0] GEN_POLY = 9'b111010001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  msg,
    output logic [14:0] codeword,
    output logic        codeword_valid
`ifdef ENCODER_15_7_SELFCHECK_EN
    ,
    output logic        check_err
`endif
);

    logic [7:0]  parity_s;
    logic [14:0] codeword_r;
    logic        valid_r;

    // Remainder of a 15-bit word modulo g(x); an unrolled long division, purely combinational.
    function automatic logic [7:0] poly_mod(input logic [14:0] word);
        logic [14:0] rem;
        rem = word;
        for (int i = 14; i >= 8; i--) begin
            if (rem[i]) begin
                rem[i -: 9] = rem[i -: 9] ^ GEN_POLY;
            end else begin
                rem = rem;
            end
        end
        return rem[7:0];
    endfunction

    // Parity of the current message word.
    always_comb begin
        parity_s = poly_mod({msg, 8'h00});
    end

    // Codeword register: samples every edge, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            codeword_r <= 15'h0000;
            valid_r    <= 1'b0;
        end else begin
            codeword_r <= {msg, parity_s};
            valid_r    <= 1'b1;
        end
    end

    assign codeword       = codeword_r;
    assign codeword_valid = valid_r;

`ifdef ENCODER_15_7_SELFCHECK_EN
    logic [7:0] syndrome_s;
    logic       check_err_s;

    // Any legal codeword is a multiple of g(x); a nonzero syndrome flags a corrupted register.
    always_comb begin
        syndrome_s = poly_mod(codeword_r);
        if (valid_r && (syndrome_s != 8'h00)) begin
            check_err_s = 1'b1;
        end else begin
            check_err_s = 1'b0;
        end
    end

    assign check_err = check_err_s;
`endif

endmodule

// File: tb/tb_encoder_15_7_core.sv
// Directed self-checking bench for encoder_15_7_core: reset, latency, back-to-back,
// exhaustive sweep against a serial-division model, linearity and mid-stream reset.
module tb_encoder_15_7_core;

    localparam logic [8:0] GEN = 9'b111010001;

    logic        clk;
    logic        reset;
    logic [6:0]  msg;
    logic [14:0] codeword;
    logic        codeword_valid;
`ifdef ENCODER_15_7_SELFCHECK_EN
    logic        check_err;
`endif

    int total;
    int bad;
    logic [14:0] obs [0:127];

    encoder_15_7_core #(.GEN_POLY(GEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .msg            (msg),
        .codeword       (codeword),
        .codeword_valid (codeword_valid)
`ifdef ENCODER_15_7_SELFCHECK_EN
        ,
        .check_err      (check_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference parity: bit-serial LFSR division of msg(x)*x^8 by g(x).
    function automatic logic [7:0] ref_parity(input logic [6:0] m);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int k = 6; k >= 0; k--) begin
            fb = m[k] ^ r[7];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ GEN[7:0];
        end
        return r;
    endfunction

    // Reference syndrome: bit-serial remainder of a 15-bit word modulo g(x).
    function automatic logic [7:0] ref_syndrome(input logic [14:0] w);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int k = 14; k >= 0; k--) begin
            fb = r[7];
            r  = {r[6:0], w[k]};
            if (fb) r = r ^ GEN[7:0];
        end
        return r;
    endfunction

    task automatic check_word(input string tag, input logic [14:0] exp_cw, input logic exp_v);
        total++;
        assert (codeword === exp_cw) else begin
            bad++;
            $error("FAIL %s codeword observed=%b expected=%b", tag, codeword, exp_cw);
        end
        total++;
        assert (codeword_valid === exp_v) else begin
            bad++;
            $error("FAIL %s valid observed=%b expected=%b", tag, codeword_valid, exp_v);
        end
`ifdef ENCODER_15_7_SELFCHECK_EN
        total++;
        assert (check_err === 1'b0) else begin
            bad++;
            $error("FAIL %s check_err observed=%b expected=0", tag, check_err);
        end
`endif
    endtask

    // Drive msg away from the edge, then sample one time unit after the capturing edge.
    task automatic step(input logic [6:0] m);
        @(negedge clk);
        msg = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        msg   = 7'b1010101;

        // Reset applied before any clock edge.
        #2;
        check_word("reset_no_edge", 15'h0000, 1'b0);

        // Outputs stay at reset values across edges and msg activity.
        step(7'h7F);
        step(7'h13);
        check_word("reset_hold", 15'h0000, 1'b0);

        // Release, then single-message latency.
        @(negedge clk);
        reset = 1'b0;
        msg   = 7'b1010101;
        @(posedge clk);
        #1;
        check_word("single_msg", 15'b101010111100101, 1'b1);

        // Back-to-back messages on consecutive edges.
        step(7'b0000001);
        check_word("b2b_0", 15'b000000111010001, 1'b1);
        step(7'b1111111);
        check_word("b2b_1", 15'b111111111111111, 1'b1);
        step(7'b0101010);
        check_word("b2b_2", 15'b010101000011010, 1'b1);
        step(7'b0000000);
        check_word("b2b_3", 15'b000000000000000, 1'b1);

        // Exhaustive sweep against the serial model, plus syndrome of every observed word.
        for (int i = 0; i < 128; i++) begin
            step(7'(i));
            obs[i] = codeword;
            check_word("sweep", {7'(i), ref_parity(7'(i))}, 1'b1);
            total++;
            assert (ref_syndrome(codeword) === 8'h00) else begin
                bad++;
                $error("FAIL sweep_syndrome msg=%0d observed=%h expected=00", i, ref_syndrome(codeword));
            end
        end

        // Linearity over observed parities.
        for (int i = 0; i < 128; i++) begin
            int j;
            logic [7:0] lhs;
            logic [7:0] rhs;
            j   = (i * 37 + 11) % 128;
            lhs = obs[i ^ j][7:0];
            rhs = obs[i][7:0] ^ obs[j][7:0];
            total++;
            assert (lhs === rhs) else begin
                bad++;
                $error("FAIL linearity a=%0d b=%0d observed=%b expected=%b", i, j, lhs, rhs);
            end
        end

        // Mid-stream reset asserted between edges.
        step(7'b1010101);
        check_word("pre_mid_reset", 15'b101010111100101, 1'b1);
        @(negedge clk);
        #2;
        msg   = 7'b1111111;
        reset = 1'b1;
        #1;
        check_word("mid_reset_immediate", 15'h0000, 1'b0);
        @(posedge clk);
        #1;
        check_word("mid_reset_hold", 15'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_word("post_release", 15'b111111111111111, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
